// File: rtl/dispatch_queue_pkg.sv
// rtl/dispatch_queue_pkg.sv - shared class codes, station codes, tag prefixes and class decode helper
//
// Imported by dispatch_entry and dispatch_queue.
//   op_class_e    : decoded instruction class presented on in_class
//   station_e     : reservation station an entry issues to
//   PREFIX_ALU/LS : top bit of a destination tag, selects the producing CDB
//   DEF_*         : default widths of the dispatch_queue parameters
//   class_info()  : per-class station, tag need, tag prefix and rename flag

package dispatch_queue_pkg;

  localparam int DEF_DEPTH      = 4;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_TAG_ROOT_W = 4;
  localparam int DEF_TAG_W      = DEF_TAG_ROOT_W + 1;
  localparam int DEF_NAME_W     = 5;
  localparam int DEF_OP_W       = 6;
  localparam int DEF_CDB_N      = 2;

  // All-zero values mark a ready tag, an unused data field and "no register".
  localparam logic [DEF_TAG_W-1:0]  TAG_FREE  = '0;
  localparam logic [DEF_DATA_W-1:0] DATA_FREE = '0;
  localparam logic [DEF_NAME_W-1:0] NAME_FREE = '0;

  localparam logic PREFIX_ALU = 1'b0;
  localparam logic PREFIX_LS  = 1'b1;

  typedef enum logic [3:0] {
    CLS_LUI   = 4'd0,
    CLS_AUIPC = 4'd1,
    CLS_JAL   = 4'd2,
    CLS_JALR  = 4'd3,
    CLS_B     = 4'd4,
    CLS_LD    = 4'd5,
    CLS_ST    = 4'd6,
    CLS_RI    = 4'd7,
    CLS_RR    = 4'd8
  } op_class_e;

  typedef enum logic [1:0] {
    STN_ALU = 2'd0,
    STN_BR  = 2'd1,
    STN_LS  = 2'd2
  } station_e;

  typedef struct packed {
    station_e stn;
    logic     need_tag;
    logic     ls_prefix;
    logic     renames;
  } class_info_t;

  // Jumps write a link register, so they travel through the ALU station and
  // produce their result under an ALU tag. Conditional branches have no
  // destination. Undefined class codes are dispatched to the ALU as no-ops.
  function automatic class_info_t class_info(input op_class_e cls);
    class_info_t r;
    case (cls)
      CLS_LUI, CLS_AUIPC, CLS_RI, CLS_RR,
      CLS_JAL, CLS_JALR: r = '{stn: STN_ALU, need_tag: 1'b1, ls_prefix: 1'b0, renames: 1'b1};
      CLS_B:             r = '{stn: STN_BR,  need_tag: 1'b0, ls_prefix: 1'b0, renames: 1'b0};
      CLS_LD:            r = '{stn: STN_LS,  need_tag: 1'b1, ls_prefix: 1'b1, renames: 1'b1};
      CLS_ST:            r = '{stn: STN_LS,  need_tag: 1'b1, ls_prefix: 1'b1, renames: 1'b0};
      default:           r = '{stn: STN_ALU, need_tag: 1'b0, ls_prefix: 1'b0, renames: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dispatch_entry.sv
// rtl/dispatch_entry.sv - one dispatch queue slot with CDB snoop and capture
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   load                write the wr_* payload into the slot (marks it valid)
//   clear               invalidate the slot (pop or flush); wins over load
//   wr_*                payload for load, source operands not yet snooped
//   cdb_valid/tag/data  packed broadcast buses
//   valid               slot holds an instruction
//   stn ... imm         stored payload; operand/tag outputs already include
//                       this cycle's CDB snoop so the issue register can load
//                       them directly

module dispatch_entry
  import dispatch_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int NAME_W = 5,
  parameter int OP_W   = 6,
  parameter int CDB_N  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clear,
  input  station_e                wr_stn,
  input  logic [OP_W-1:0]         wr_op,
  input  logic [DATA_W-1:0]       wr_operand_o,
  input  logic [TAG_W-1:0]        wr_tag_o,
  input  logic [DATA_W-1:0]       wr_operand_t,
  input  logic [TAG_W-1:0]        wr_tag_t,
  input  logic [TAG_W-1:0]        wr_tag_w,
  input  logic [NAME_W-1:0]       wr_name_w,
  input  logic [DATA_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_imm,
  input  logic [CDB_N-1:0]        cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_N*DATA_W-1:0] cdb_data,
  output logic                    valid,
  output station_e                stn,
  output logic [OP_W-1:0]         op,
  output logic [DATA_W-1:0]       operand_o,
  output logic [TAG_W-1:0]        tag_o,
  output logic [DATA_W-1:0]       operand_t,
  output logic [TAG_W-1:0]        tag_t,
  output logic [TAG_W-1:0]        tag_w,
  output logic [NAME_W-1:0]       name_w,
  output logic [DATA_W-1:0]       addr,
  output logic [DATA_W-1:0]       imm
);

  logic [DATA_W-1:0] s_operand_o, s_operand_t;
  logic [TAG_W-1:0]  s_tag_o, s_tag_t;
  logic [DATA_W-1:0] nxt_operand_o, nxt_operand_t;
  logic [TAG_W-1:0]  nxt_tag_o, nxt_tag_t;

  // A waiting operand takes the data of a matching broadcast and becomes
  // ready. The buses are walked from the highest index down so that the
  // lowest-index match is written last and wins.
  function automatic logic [TAG_W+DATA_W-1:0] snoop(input logic [TAG_W-1:0]  t,
                                                    input logic [DATA_W-1:0] d);
    logic [TAG_W-1:0]  rt;
    logic [DATA_W-1:0] rd;
    rt = t;
    rd = d;
    for (int i = CDB_N - 1; i >= 0; i--) begin
      if (cdb_valid[i] && (t != '0) && (cdb_tag[i*TAG_W +: TAG_W] == t)) begin
        rt = '0;
        rd = cdb_data[i*DATA_W +: DATA_W];
      end
    end
    return {rt, rd};
  endfunction

  // The load path is snooped too, so a result broadcast in the enqueue cycle
  // is not lost while the regfile read still shows the tag.
  always_comb begin
    {nxt_tag_o, nxt_operand_o} = snoop(load ? wr_tag_o : s_tag_o,
                                       load ? wr_operand_o : s_operand_o);
    {nxt_tag_t, nxt_operand_t} = snoop(load ? wr_tag_t : s_tag_t,
                                       load ? wr_operand_t : s_operand_t);
    {tag_o, operand_o}         = snoop(s_tag_o, s_operand_o);
    {tag_t, operand_t}         = snoop(s_tag_t, s_operand_t);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid       <= 1'b0;
      stn         <= STN_ALU;
      op          <= '0;
      s_operand_o <= '0;
      s_tag_o     <= '0;
      s_operand_t <= '0;
      s_tag_t     <= '0;
      tag_w       <= '0;
      name_w      <= '0;
      addr        <= '0;
      imm         <= '0;
    end else begin
      if (clear) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end
      s_operand_o <= nxt_operand_o;
      s_tag_o     <= nxt_tag_o;
      s_operand_t <= nxt_operand_t;
      s_tag_t     <= nxt_tag_t;
      if (load) begin
        stn    <= wr_stn;
        op     <= wr_op;
        tag_w  <= wr_tag_w;
        name_w <= wr_name_w;
        addr   <= wr_addr;
        imm    <= wr_imm;
      end
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order dispatch FIFO between decoder and reservation stations
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   in_valid/in_ready             decoder handshake
//   in_class..in_bimm             decoded instruction fields and immediates
//   reg_tag_*/reg_data_*          regfile read of the current decode
//   cdb_valid/tag/data            snooped broadcast buses (packed, bus 0 lowest)
//   *_free_valid/*_free_tag       free-tag table heads; *_alloc reserves them
//   ren_en/ren_tag/ren_name       regfile rename write at the enqueue edge
//   alu/br/ls_ready               station can take an entry this cycle
//   flush                         drop all queued entries and any enqueue
//   alu/br/ls_en + payload        registered one-cycle issue to a station

module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 32,
  parameter int TAG_ROOT_W = 4,
  parameter int NAME_W     = 5,
  parameter int OP_W       = 6,
  parameter int CDB_N      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  op_class_e                        in_class,
  input  logic [OP_W-1:0]                  in_op,
  input  logic [NAME_W-1:0]                in_rd,
  input  logic [DATA_W-1:0]                in_addr,
  input  logic [DATA_W-1:0]                in_imm,
  input  logic [DATA_W-1:0]                in_uimm,
  input  logic [DATA_W-1:0]                in_jimm,
  input  logic [DATA_W-1:0]                in_simm,
  input  logic [DATA_W-1:0]                in_bimm,
  input  logic [TAG_ROOT_W:0]              reg_tag_o,
  input  logic [DATA_W-1:0]                reg_data_o,
  input  logic [TAG_ROOT_W:0]              reg_tag_t,
  input  logic [DATA_W-1:0]                reg_data_t,
  input  logic [CDB_N-1:0]                 cdb_valid,
  input  logic [CDB_N*(TAG_ROOT_W+1)-1:0]  cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]          cdb_data,
  input  logic                             alu_free_valid,
  input  logic [TAG_ROOT_W-1:0]            alu_free_tag,
  input  logic                             ls_free_valid,
  input  logic [TAG_ROOT_W-1:0]            ls_free_tag,
  output logic                             alu_alloc,
  output logic                             ls_alloc,
  output logic                             ren_en,
  output logic [TAG_ROOT_W:0]              ren_tag,
  output logic [NAME_W-1:0]                ren_name,
  input  logic                             alu_ready,
  input  logic                             br_ready,
  input  logic                             ls_ready,
  input  logic                             flush,
  output logic                             alu_en,
  output logic                             br_en,
  output logic                             ls_en,
  output logic [OP_W-1:0]                  op,
  output logic [DATA_W-1:0]                operand_o,
  output logic [DATA_W-1:0]                operand_t,
  output logic [TAG_ROOT_W:0]              tag_o,
  output logic [TAG_ROOT_W:0]              tag_t,
  output logic [TAG_ROOT_W:0]              tag_w,
  output logic [NAME_W-1:0]                name_w,
  output logic [DATA_W-1:0]                addr,
  output logic [DATA_W-1:0]                imm_out,
  output logic                             already_rdy
);

  localparam int TAG_W = TAG_ROOT_W + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------- enqueue decode ----------------
  class_info_t       info;
  logic [DATA_W-1:0] d_operand_o, d_operand_t, d_imm;
  logic [TAG_W-1:0]  d_tag_o, d_tag_t, d_tag_w;
  logic [NAME_W-1:0] d_name_w;
  logic              tag_ok, enq, full;

  always_comb begin
    info        = class_info(in_class);
    d_operand_o = reg_data_o;
    d_tag_o     = reg_tag_o;
    d_operand_t = '0;
    d_tag_t     = '0;
    d_imm       = '0;
    d_name_w    = in_rd;
    case (in_class)
      CLS_LUI, CLS_AUIPC: d_operand_t = in_uimm;
      CLS_RI, CLS_JALR:   d_operand_t = in_imm;
      CLS_JAL: begin
        d_operand_o = in_addr;
        d_tag_o     = '0;
        d_operand_t = in_jimm;
      end
      CLS_RR: begin
        d_operand_t = reg_data_t;
        d_tag_t     = reg_tag_t;
      end
      CLS_B: begin
        d_operand_t = reg_data_t;
        d_tag_t     = reg_tag_t;
        d_imm       = in_bimm;
        d_name_w    = '0;
      end
      CLS_LD: d_imm = in_imm;
      CLS_ST: begin
        d_operand_t = reg_data_t;
        d_tag_t     = reg_tag_t;
        d_imm       = in_simm;
        d_name_w    = '0;
      end
      default: ;
    endcase

    if (!info.need_tag) begin
      d_tag_w = '0;
      tag_ok  = 1'b1;
    end else if (info.ls_prefix) begin
      d_tag_w = {PREFIX_LS, ls_free_tag};
      tag_ok  = ls_free_valid;
    end else begin
      d_tag_w = {PREFIX_ALU, alu_free_tag};
      tag_ok  = alu_free_valid;
    end
  end

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wptr, rptr;

  assign full      = (count == CNT_W'(DEPTH));
  assign in_ready  = rst && !full && !flush && tag_ok;
  assign enq       = in_valid && in_ready;
  assign alu_alloc = enq && info.need_tag && !info.ls_prefix;
  assign ls_alloc  = enq && info.need_tag && info.ls_prefix;
  assign ren_en    = enq && info.renames;
  assign ren_tag   = d_tag_w;
  assign ren_name  = in_rd;

  // ---------------- queue slots ----------------
  logic              e_valid [DEPTH];
  station_e          e_stn   [DEPTH];
  logic [OP_W-1:0]   e_op    [DEPTH];
  logic [DATA_W-1:0] e_opd_o [DEPTH];
  logic [TAG_W-1:0]  e_tag_o [DEPTH];
  logic [DATA_W-1:0] e_opd_t [DEPTH];
  logic [TAG_W-1:0]  e_tag_t [DEPTH];
  logic [TAG_W-1:0]  e_tag_w [DEPTH];
  logic [NAME_W-1:0] e_name  [DEPTH];
  logic [DATA_W-1:0] e_addr  [DEPTH];
  logic [DATA_W-1:0] e_imm   [DEPTH];
  logic              fire;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    dispatch_entry #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .NAME_W (NAME_W),
      .OP_W   (OP_W),
      .CDB_N  (CDB_N)
    ) u_entry (
      .clk          (clk),
      .rst          (rst),
      .load         (enq && (wptr == PTR_W'(i))),
      .clear        (flush || (fire && (rptr == PTR_W'(i)))),
      .wr_stn       (info.stn),
      .wr_op        (in_op),
      .wr_operand_o (d_operand_o),
      .wr_tag_o     (d_tag_o),
      .wr_operand_t (d_operand_t),
      .wr_tag_t     (d_tag_t),
      .wr_tag_w     (d_tag_w),
      .wr_name_w    (d_name_w),
      .wr_addr      (in_addr),
      .wr_imm       (d_imm),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_data     (cdb_data),
      .valid        (e_valid[i]),
      .stn          (e_stn[i]),
      .op           (e_op[i]),
      .operand_o    (e_opd_o[i]),
      .tag_o        (e_tag_o[i]),
      .operand_t    (e_opd_t[i]),
      .tag_t        (e_tag_t[i]),
      .tag_w        (e_tag_w[i]),
      .name_w       (e_name[i]),
      .addr         (e_addr[i]),
      .imm          (e_imm[i])
    );
  end

  // ---------------- issue ----------------
  station_e h_stn;
  logic     stn_ready;

  always_comb begin
    h_stn = e_stn[rptr];
    case (h_stn)
      STN_ALU: stn_ready = alu_ready;
      STN_BR:  stn_ready = br_ready;
      STN_LS:  stn_ready = ls_ready;
      default: stn_ready = 1'b0;
    endcase
    fire = e_valid[rptr] && stn_ready && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (enq) wptr <= wptr + PTR_W'(1);
      if (fire) rptr <= rptr + PTR_W'(1);
      case ({enq, fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Slot outputs already carry the same-cycle snoop, so a result broadcast
  // in the issue cycle reaches the station with the payload.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_en      <= 1'b0;
      br_en       <= 1'b0;
      ls_en       <= 1'b0;
      op          <= '0;
      operand_o   <= '0;
      operand_t   <= '0;
      tag_o       <= '0;
      tag_t       <= '0;
      tag_w       <= '0;
      name_w      <= '0;
      addr        <= '0;
      imm_out     <= '0;
      already_rdy <= 1'b0;
    end else begin
      alu_en <= fire && (h_stn == STN_ALU);
      br_en  <= fire && (h_stn == STN_BR);
      ls_en  <= fire && (h_stn == STN_LS);
      if (fire) begin
        op          <= e_op[rptr];
        operand_o   <= e_opd_o[rptr];
        operand_t   <= e_opd_t[rptr];
        tag_o       <= e_tag_o[rptr];
        tag_t       <= e_tag_t[rptr];
        tag_w       <= e_tag_w[rptr];
        name_w      <= e_name[rptr];
        addr        <= e_addr[rptr];
        imm_out     <= e_imm[rptr];
        already_rdy <= (e_tag_o[rptr] == '0) && (e_tag_t[rptr] == '0);
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - randomized scoreboard bench for dispatch_queue

module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int TRW   = 4;
  localparam int TW    = TRW + 1;
  localparam int NW    = 5;
  localparam int OW    = 6;
  localparam int CN    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  op_class_e       in_class;
  logic [OW-1:0]   in_op;
  logic [NW-1:0]   in_rd;
  logic [DW-1:0]   in_addr, in_imm, in_uimm, in_jimm, in_simm, in_bimm;
  logic [TW-1:0]   reg_tag_o, reg_tag_t;
  logic [DW-1:0]   reg_data_o, reg_data_t;
  logic [CN-1:0]   cdb_valid;
  logic [CN*TW-1:0] cdb_tag;
  logic [CN*DW-1:0] cdb_data;
  logic            alu_free_valid, ls_free_valid;
  logic [TRW-1:0]  alu_free_tag, ls_free_tag;
  logic            alu_alloc, ls_alloc, ren_en;
  logic [TW-1:0]   ren_tag;
  logic [NW-1:0]   ren_name;
  logic            alu_ready, br_ready, ls_ready, flush;
  logic            alu_en, br_en, ls_en;
  logic [OW-1:0]   op;
  logic [DW-1:0]   operand_o, operand_t, addr, imm_out;
  logic [TW-1:0]   tag_o, tag_t, tag_w;
  logic [NW-1:0]   name_w;
  logic            already_rdy;

  dispatch_queue #(
    .DEPTH(DEPTH), .DATA_W(DW), .TAG_ROOT_W(TRW), .NAME_W(NW), .OP_W(OW), .CDB_N(CN)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_op(in_op), .in_rd(in_rd), .in_addr(in_addr),
    .in_imm(in_imm), .in_uimm(in_uimm), .in_jimm(in_jimm), .in_simm(in_simm), .in_bimm(in_bimm),
    .reg_tag_o(reg_tag_o), .reg_data_o(reg_data_o), .reg_tag_t(reg_tag_t), .reg_data_t(reg_data_t),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_free_valid(alu_free_valid), .alu_free_tag(alu_free_tag),
    .ls_free_valid(ls_free_valid), .ls_free_tag(ls_free_tag),
    .alu_alloc(alu_alloc), .ls_alloc(ls_alloc),
    .ren_en(ren_en), .ren_tag(ren_tag), .ren_name(ren_name),
    .alu_ready(alu_ready), .br_ready(br_ready), .ls_ready(ls_ready), .flush(flush),
    .alu_en(alu_en), .br_en(br_en), .ls_en(ls_en),
    .op(op), .operand_o(operand_o), .operand_t(operand_t),
    .tag_o(tag_o), .tag_t(tag_t), .tag_w(tag_w), .name_w(name_w),
    .addr(addr), .imm_out(imm_out), .already_rdy(already_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    station_e      stn;
    logic [OW-1:0] op;
    logic [DW-1:0] o, t;
    logic [TW-1:0] to, tt, tw;
    logic [NW-1:0] nw;
    logic [DW-1:0] addr, imm;
  } ment_t;

  ment_t mq[$];     // instructions the reference believes are queued
  ment_t exp_q[$];  // issues expected to appear on the outputs next cycle

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  run      = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] rtag();
    int r;
    r = $urandom_range(0, 5);
    if (r < 2) return '0;
    return {1'($urandom_range(0, 1)), 4'(r - 1)};
  endfunction

  // Result forwarding: a pending (nonzero) tag seen on any valid bus takes
  // that bus's data; the first bus in index order that matches is used.
  task automatic snp(inout logic [TW-1:0] t, inout logic [DW-1:0] d);
    bit hit;
    hit = 0;
    for (int i = 0; i < CN; i++) begin
      if (!hit && t != 0 && cdb_valid[i] && cdb_tag[i*TW +: TW] == t) begin
        d   = cdb_data[i*DW +: DW];
        hit = 1;
      end
    end
    if (hit) t = '0;
  endtask

  function automatic bit cls_alu_tag(op_class_e c);
    return c inside {CLS_LUI, CLS_AUIPC, CLS_RI, CLS_JAL, CLS_JALR, CLS_RR};
  endfunction

  function automatic bit cls_ls_tag(op_class_e c);
    return c inside {CLS_LD, CLS_ST};
  endfunction

  function automatic ment_t build();
    ment_t e;
    e.op = in_op; e.addr = in_addr; e.nw = in_rd; e.imm = '0;
    e.o = reg_data_o; e.to = reg_tag_o; e.t = reg_data_t; e.tt = reg_tag_t;
    e.stn = STN_ALU;
    case (in_class)
      CLS_LUI, CLS_AUIPC: begin e.t = in_uimm; e.tt = 0; end
      CLS_RI, CLS_JALR:   begin e.t = in_imm;  e.tt = 0; end
      CLS_JAL: begin e.o = in_addr; e.to = 0; e.t = in_jimm; e.tt = 0; end
      CLS_RR: ;
      CLS_B:  begin e.stn = STN_BR; e.imm = in_bimm; e.nw = 0; end
      CLS_LD: begin e.stn = STN_LS; e.t = 0; e.tt = 0; e.imm = in_imm; end
      CLS_ST: begin e.stn = STN_LS; e.imm = in_simm; e.nw = 0; end
      default: ;
    endcase
    if (cls_alu_tag(in_class))     e.tw = {PREFIX_ALU, alu_free_tag};
    else if (cls_ls_tag(in_class)) e.tw = {PREFIX_LS, ls_free_tag};
    else                           e.tw = '0;
    return e;
  endfunction

  function automatic bit stn_rdy(station_e s);
    case (s)
      STN_ALU: return alu_ready;
      STN_BR:  return br_ready;
      default: return ls_ready;
    endcase
  endfunction

  task automatic drive_random(input int rdy_pct, input int valid_pct, input int flush_pct);
    in_valid   = ($urandom_range(0, 99) < valid_pct);
    in_class   = op_class_e'(4'($urandom_range(0, 8)));
    in_op      = OW'($urandom);
    in_rd      = NW'($urandom);
    in_addr    = $urandom; in_imm  = $urandom; in_uimm = $urandom;
    in_jimm    = $urandom; in_simm = $urandom; in_bimm = $urandom;
    reg_tag_o  = rtag();   reg_tag_t = rtag();
    reg_data_o = $urandom; reg_data_t = $urandom;
    for (int i = 0; i < CN; i++) begin
      cdb_valid[i]          = ($urandom_range(0, 99) < 40);
      cdb_tag[i*TW +: TW]   = rtag();
      cdb_data[i*DW +: DW]  = $urandom;
    end
    alu_free_valid = ($urandom_range(0, 99) < 85);
    ls_free_valid  = ($urandom_range(0, 99) < 85);
    alu_free_tag   = TRW'($urandom);
    ls_free_tag    = TRW'($urandom);
    alu_ready      = ($urandom_range(0, 99) < rdy_pct);
    br_ready       = ($urandom_range(0, 99) < rdy_pct);
    ls_ready       = ($urandom_range(0, 99) < rdy_pct);
    flush          = ($urandom_range(0, 99) < flush_pct);
  endtask

  // Checks the decoder-side handshake and advances the reference by one edge.
  task automatic model_step();
    bit    need_a, need_l, exp_rdy, acc;
    ment_t e;
    need_a  = cls_alu_tag(in_class);
    need_l  = cls_ls_tag(in_class);
    exp_rdy = !flush && (mq.size() < DEPTH) &&
              (need_a ? alu_free_valid : (need_l ? ls_free_valid : 1'b1));
    acc     = in_valid && exp_rdy;
    e       = build();
    chk("in_ready", in_ready, exp_rdy);
    chk("alu_alloc", alu_alloc, acc && need_a);
    chk("ls_alloc", ls_alloc, acc && need_l);
    chk("ren_en", ren_en, acc && !(in_class inside {CLS_B, CLS_ST}));
    if (acc && !(in_class inside {CLS_B, CLS_ST})) begin
      chk("ren_tag", ren_tag, e.tw);
      chk("ren_name", ren_name, in_rd);
    end
    for (int i = 0; i < mq.size(); i++) begin
      snp(mq[i].to, mq[i].o);
      snp(mq[i].tt, mq[i].t);
    end
    if (flush) mq.delete();
    else if (mq.size() > 0 && stn_rdy(mq[0].stn)) exp_q.push_back(mq.pop_front());
    if (acc) begin
      snp(e.to, e.o);
      snp(e.tt, e.t);
      mq.push_back(e);
    end
  endtask

  // Monitor: whatever the DUT issues is compared against the scoreboard.
  always @(negedge clk) begin
    if (run) begin
      int    ens;
      ment_t x;
      ens = int'(alu_en) + int'(br_en) + int'(ls_en);
      chk("one_hot_en", ens <= 1, 1'b1);
      if (ens != 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", {alu_en, br_en, ls_en}, 3'b000);
        end else begin
          x = exp_q.pop_front();
          chk("issue_station", {alu_en, br_en, ls_en},
              {x.stn == STN_ALU, x.stn == STN_BR, x.stn == STN_LS});
          chk("issue_payload",
              {op, operand_o, operand_t, tag_o, tag_t, tag_w, name_w, addr, imm_out, already_rdy},
              {x.op, x.o, x.t, x.to, x.tt, x.tw, x.nw, x.addr, x.imm, (x.to == 0 && x.tt == 0)});
        end
      end else if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("missing_issue", {alu_en, br_en, ls_en},
            {x.stn == STN_ALU, x.stn == STN_BR, x.stn == STN_LS});
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive_random(50, 100, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_random(50, 100, 0);
      #1;
      chk("reset_in_ready", in_ready, 1'b0);
      chk("reset_outputs",
          {alu_en, br_en, ls_en, op, operand_o, operand_t, tag_o, tag_t, tag_w,
           name_w, addr, imm_out, already_rdy}, '0);
    end

    for (int c = 0; c < 2400; c++) begin
      @(negedge clk);
      rst = 1'b1;
      run = 1;
      if (c < 800)       drive_random(60, 70, 2);
      else if (c < 1400) drive_random(10, 80, 1);
      else               drive_random(90, 60, 3);
      #1;
      model_step();
    end

    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      drive_random(100, 0, 0);
      alu_ready = 1'b1; br_ready = 1'b1; ls_ready = 1'b1;
      #1;
      model_step();
    end

    @(negedge clk);
    #1;
    chk("drained_model_queue", 32'(mq.size()), 32'd0);
    chk("drained_scoreboard", 32'(exp_q.size()), 32'd0);
    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
